chanels_result_arbiter: RTL and testbench

//  Collects per-channel post-processed results (amplitude AC, phase PH) from the CHANELS postprocessor lanes.

---
 rtl/chanels_result_arbiter.sv | 128 ++++++++++++
 tb/tb_chanels_result_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/chanels_result_arbiter.sv
// Round-robin arbiter: per-lane one-entry holding slots feeding a single valid/ready
// result stream, with a sticky per-lane overflow flag for dropped results.
module chanels_result_arbiter #(
   parameter int CHANELS = 4,
   parameter int WIDTH   = 32
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [CHANELS-1:0]           i_vld,
   input  logic [CHANELS*WIDTH-1:0]     i_ac,
   input  logic [CHANELS*WIDTH-1:0]     i_ph,
   input  logic                         i_rdy,
   input  logic                         i_clr_ovf,
   output logic                         o_vld,
   output logic [$clog2(CHANELS)-1:0]   o_addres,
   output logic [WIDTH-1:0]             o_ac,
   output logic [WIDTH-1:0]             o_ph,
   output logic [CHANELS-1:0]           o_ovf
);

   localparam int AW = $clog2(CHANELS);

   logic             full_q [CHANELS];
   logic [WIDTH-1:0] slot_ac_q [CHANELS];
   logic [WIDTH-1:0] slot_ph_q [CHANELS];

   logic [AW-1:0]       ptr_q;
   logic [AW-1:0]       ptr_d;
   logic                vld_q;
   logic [AW-1:0]       addr_q;
   logic [WIDTH-1:0]    ac_q;
   logic [WIDTH-1:0]    ph_q;
   logic [CHANELS-1:0]  ovf_q;
   logic [CHANELS-1:0]  ovf_d;
   logic [CHANELS-1:0]  ovf_set;

   logic          loadable;
   logic          grant_vld;
   logic [AW-1:0] grant_idx;
   logic [AW:0]   cand;
   logic          take;

   assign loadable = !vld_q || i_rdy;
   assign take     = loadable && grant_vld;

   // Scan downwards so the last hit is the first full slot at or after ptr.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = CHANELS - 1; i >= 0; i--) begin
         cand = {1'b0, ptr_q} + (AW+1)'(i);
         if (cand >= (AW+1)'(CHANELS)) begin
            cand = cand - (AW+1)'(CHANELS);
         end
         if (full_q[cand[AW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[AW-1:0];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (take) begin
         ptr_d = (grant_idx == AW'(CHANELS - 1)) ? '0 : grant_idx + AW'(1);
      end
   end

   // A set in the same cycle as a clear wins.
   assign ovf_d = ovf_set | (i_clr_ovf ? '0 : ovf_q);

   generate
      for (genvar gi = 0; gi < CHANELS; gi++) begin : g_slot
         logic granted;
         logic capture;

         assign granted     = take && (grant_idx == AW'(gi));
         assign capture     = i_vld[gi] && (!full_q[gi] || granted);
         assign ovf_set[gi] = i_vld[gi] && full_q[gi] && !granted;

         always_ff @(posedge clk) begin
            if (!rstn) begin
               full_q[gi]    <= 1'b0;
               slot_ac_q[gi] <= '0;
               slot_ph_q[gi] <= '0;
            end else if (capture) begin
               full_q[gi]    <= 1'b1;
               slot_ac_q[gi] <= i_ac[gi*WIDTH +: WIDTH];
               slot_ph_q[gi] <= i_ph[gi*WIDTH +: WIDTH];
            end else if (granted) begin
               full_q[gi]    <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_q  <= 1'b0;
         addr_q <= '0;
         ac_q   <= '0;
         ph_q   <= '0;
         ovf_q  <= '0;
         ptr_q  <= '0;
      end else begin
         ovf_q <= ovf_d;
         ptr_q <= ptr_d;
         if (loadable) begin
            if (grant_vld) begin
               vld_q  <= 1'b1;
               addr_q <= grant_idx;
               ac_q   <= slot_ac_q[grant_idx];
               ph_q   <= slot_ph_q[grant_idx];
            end else begin
               vld_q  <= 1'b0;
            end
         end
      end
   end

   assign o_vld    = vld_q;
   assign o_addres = addr_q;
   assign o_ac     = ac_q;
   assign o_ph     = ph_q;
   assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_chanels_result_arbiter.sv
// Directed bench for chanels_result_arbiter: a per-cycle vector table plus hand sequences
// for single word, reset mid-operation and pointer wrap with three lanes.
module tb_chanels_result_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rstn;
   logic [N-1:0]   i_vld;
   logic [N*W-1:0] i_ac;
   logic [N*W-1:0] i_ph;
   logic           i_rdy;
   logic           i_clr_ovf;
   logic           o_vld;
   logic [1:0]     o_addres;
   logic [W-1:0]   o_ac;
   logic [W-1:0]   o_ph;
   logic [N-1:0]   o_ovf;

   logic           rstn3;
   logic [2:0]     vld3;
   logic [3*W-1:0] ac3;
   logic [3*W-1:0] ph3;
   logic           rdy3;
   logic           clr3;
   logic           o_vld3;
   logic [1:0]     o_addr3;
   logic [W-1:0]   o_ac3;
   logic [W-1:0]   o_ph3;
   logic [2:0]     o_ovf3;

   always #5 clk = ~clk;

   chanels_result_arbiter #(.CHANELS(N), .WIDTH(W)) dut (
      .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_ac(i_ac), .i_ph(i_ph),
      .i_rdy(i_rdy), .i_clr_ovf(i_clr_ovf), .o_vld(o_vld), .o_addres(o_addres),
      .o_ac(o_ac), .o_ph(o_ph), .o_ovf(o_ovf)
   );

   chanels_result_arbiter #(.CHANELS(3), .WIDTH(W)) dut3 (
      .clk(clk), .rstn(rstn3), .i_vld(vld3), .i_ac(ac3), .i_ph(ph3),
      .i_rdy(rdy3), .i_clr_ovf(clr3), .o_vld(o_vld3), .o_addres(o_addr3),
      .o_ac(o_ac3), .o_ph(o_ph3), .o_ovf(o_ovf3)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [31:0] acb;
      logic [31:0] phb;
      logic        rdy;
      logic        clr;
      logic        e_vld;
      logic [1:0]  e_addr;
      logic [31:0] e_ac;
      logic [31:0] e_ph;
      logic [3:0]  e_ovf;
   } row_t;

   row_t tbl[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] vld, input logic [31:0] acb, input logic [31:0] phb,
                      input logic rdy, input logic clr, input logic ev, input logic [1:0] ea,
                      input logic [31:0] eac, input logic [31:0] eph, input logic [3:0] eovf);
      tbl.push_back('{vld, acb, phb, rdy, clr, ev, ea, eac, eph, eovf});
   endtask

   // Lane k gets acb + k*0x100 and phb - k so the bench can tell lanes apart by data.
   task automatic drive(input logic [3:0] vld, input logic [31:0] acb, input logic [31:0] phb,
                        input logic rdy, input logic clr);
      i_vld     = vld;
      i_rdy     = rdy;
      i_clr_ovf = clr;
      for (int k = 0; k < N; k++) begin
         i_ac[k*W +: W] = acb + 32'(k) * 32'h100;
         i_ph[k*W +: W] = phb - 32'(k);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic show(input string tag);
      $display("[TB] %s vld=%0b addr=%0d ac=%h ph=%h ovf=%b", tag, o_vld, o_addres, o_ac, o_ph, o_ovf);
   endtask

   initial begin
      rstn = 1'b0; rstn3 = 1'b0;
      drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
      vld3 = '0; ac3 = '0; ph3 = '0; rdy3 = 1'b0; clr3 = 1'b0;
      repeat (3) step();
      rstn = 1'b1; rstn3 = 1'b1;

      chk("reset o_vld", 32'(o_vld), 32'h0);
      chk("reset o_addres", 32'(o_addres), 32'h0);
      chk("reset o_ac", o_ac, 32'h0);
      chk("reset o_ph", o_ph, 32'h0);
      chk("reset o_ovf", 32'(o_ovf), 32'h0);

      // Single word on lane 2, two-edge latency, one cycle wide
      drive(4'b0100, 32'h0, 32'h0, 1'b1, 1'b0);
      i_ac[2*W +: W] = 32'h11;
      i_ph[2*W +: W] = -32'sd5;
      step(); show("single capture");
      chk("single t+1 o_vld", 32'(o_vld), 32'h0);
      drive(4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
      step(); show("single out");
      chk("single o_vld", 32'(o_vld), 32'h1);
      chk("single o_addres", 32'(o_addres), 32'h2);
      chk("single o_ac", o_ac, 32'h11);
      chk("single o_ph", o_ph, 32'hFFFFFFFB);
      step(); show("single after");
      chk("single one-cycle", 32'(o_vld), 32'h0);

      rstn = 1'b0; step(); rstn = 1'b1;

      add(4'b1111, 32'hA0000000, 32'h100, 1, 0, 0, 0, 32'h0,        32'h0,        4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 0, 32'hA0000000, 32'h00000100, 4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 1, 32'hA0000100, 32'h000000FF, 4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 2, 32'hA0000200, 32'h000000FE, 4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 3, 32'hA0000300, 32'h000000FD, 4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 0, 3, 32'hA0000300, 32'h000000FD, 4'b0000);
      add(4'b0010, 32'hB0000000, 32'h80000000, 0, 0, 0, 3, 32'hA0000300, 32'h000000FD, 4'b0000);
      for (int k = 0; k < 6; k++)
         add(4'b0000, 32'h0, 32'h0,       0, 0, 1, 1, 32'hB0000100, 32'h7FFFFFFF, 4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 0, 1, 32'hB0000100, 32'h7FFFFFFF, 4'b0000);
      add(4'b0001, 32'hE0000000, 32'h5,   0, 0, 0, 1, 32'hB0000100, 32'h7FFFFFFF, 4'b0000);
      add(4'b0010, 32'hC0000000, 32'h11,  0, 0, 1, 0, 32'hE0000000, 32'h00000005, 4'b0000);
      add(4'b0010, 32'hD0000000, 32'h22,  0, 0, 1, 0, 32'hE0000000, 32'h00000005, 4'b0010);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 1, 32'hC0000100, 32'h00000010, 4'b0010);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 0, 1, 32'hC0000100, 32'h00000010, 4'b0010);
      add(4'b0000, 32'h0, 32'h0,          1, 1, 0, 1, 32'hC0000100, 32'h00000010, 4'b0000);
      add(4'b0001, 32'hF0000000, 32'h1,   0, 0, 0, 1, 32'hC0000100, 32'h00000010, 4'b0000);
      add(4'b0010, 32'h12340000, 32'h33,  0, 0, 1, 0, 32'hF0000000, 32'h00000001, 4'b0000);
      add(4'b0010, 32'h55550000, 32'h44,  0, 1, 1, 0, 32'hF0000000, 32'h00000001, 4'b0010);
      add(4'b0000, 32'h0, 32'h0,          0, 1, 1, 0, 32'hF0000000, 32'h00000001, 4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 1, 32'h12340100, 32'h00000032, 4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 0, 1, 32'h12340100, 32'h00000032, 4'b0000);
      add(4'b1000, 32'h30000000, 32'h3,   0, 0, 0, 1, 32'h12340100, 32'h00000032, 4'b0000);
      add(4'b0101, 32'h40000000, 32'h40,  0, 0, 1, 3, 32'h30000300, 32'h00000000, 4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 0, 32'h40000000, 32'h00000040, 4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 2, 32'h40000200, 32'h0000003E, 4'b0000);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 0, 2, 32'h40000200, 32'h0000003E, 4'b0000);
      add(4'b1111, 32'h60000000, 32'h0,   1, 0, 0, 2, 32'h40000200, 32'h0000003E, 4'b0000);
      add(4'b1111, 32'h70000000, 32'h0,   1, 0, 1, 3, 32'h60000300, 32'hFFFFFFFD, 4'b0111);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 0, 32'h60000000, 32'h00000000, 4'b0111);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 1, 32'h60000100, 32'hFFFFFFFF, 4'b0111);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 2, 32'h60000200, 32'hFFFFFFFE, 4'b0111);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 1, 3, 32'h70000300, 32'hFFFFFFFD, 4'b0111);
      add(4'b0000, 32'h0, 32'h0,          1, 0, 0, 3, 32'h70000300, 32'hFFFFFFFD, 4'b0111);
      add(4'b0000, 32'h0, 32'h0,          1, 1, 0, 3, 32'h70000300, 32'hFFFFFFFD, 4'b0000);

      for (int r = 0; r < tbl.size(); r++) begin
         drive(tbl[r].vld, tbl[r].acb, tbl[r].phb, tbl[r].rdy, tbl[r].clr);
         step();
         show($sformatf("row %0d", r));
         chk($sformatf("row %0d o_vld", r), 32'(o_vld), 32'(tbl[r].e_vld));
         chk($sformatf("row %0d o_addres", r), 32'(o_addres), 32'(tbl[r].e_addr));
         chk($sformatf("row %0d o_ac", r), o_ac, tbl[r].e_ac);
         chk($sformatf("row %0d o_ph", r), o_ph, tbl[r].e_ph);
         chk($sformatf("row %0d o_ovf", r), 32'(o_ovf), 32'(tbl[r].e_ovf));
      end

      // Reset mid-operation with lanes 1..3 pending and lane 0 on the output
      drive(4'b0111, 32'h90000000, 32'h0, 1'b0, 1'b0);
      step(); show("midrst load");
      drive(4'b1000, 32'h90000000, 32'h0, 1'b0, 1'b0);
      step(); show("midrst busy");
      chk("midrst pre o_vld", 32'(o_vld), 32'h1);
      chk("midrst pre o_addres", 32'(o_addres), 32'h0);
      rstn = 1'b0;
      drive(4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
      step(); show("midrst reset");
      rstn = 1'b1;
      chk("midrst o_vld", 32'(o_vld), 32'h0);
      chk("midrst o_addres", 32'(o_addres), 32'h0);
      chk("midrst o_ac", o_ac, 32'h0);
      chk("midrst o_ph", o_ph, 32'h0);
      chk("midrst o_ovf", 32'(o_ovf), 32'h0);
      for (int k = 0; k < 4; k++) begin
         step(); show("midrst idle");
         chk($sformatf("midrst idle %0d o_vld", k), 32'(o_vld), 32'h0);
      end
      drive(4'b1001, 32'hA5000000, 32'h0, 1'b1, 1'b0);
      step();
      drive(4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
      step(); show("midrst grant");
      chk("midrst first grant", 32'(o_addres), 32'h0);
      chk("midrst first o_vld", 32'(o_vld), 32'h1);
      step(); show("midrst grant");
      chk("midrst second grant", 32'(o_addres), 32'h3);
      chk("midrst second o_ac", o_ac, 32'hA5000300);
      step();
      chk("midrst drained", 32'(o_vld), 32'h0);

      // Three lanes: grant to lane 2 must wrap the pointer back to 0
      vld3 = 3'b100; ac3 = {32'h0000_0C02, 32'h0, 32'h0}; rdy3 = 1'b0;
      step();
      vld3 = 3'b000;
      step();
      $display("[TB] c3 vld=%0b addr=%0d ac=%h", o_vld3, o_addr3, o_ac3);
      chk("c3 grant lane2", 32'(o_addr3), 32'h2);
      chk("c3 lane2 o_ac", o_ac3, 32'h0000_0C02);
      vld3 = 3'b011; ac3 = {32'h0, 32'h0000_0C01, 32'h0000_0C00};
      step();
      vld3 = 3'b000; rdy3 = 1'b1;
      chk("c3 held", 32'(o_addr3), 32'h2);
      step();
      $display("[TB] c3 vld=%0b addr=%0d ac=%h", o_vld3, o_addr3, o_ac3);
      chk("c3 wrap grant lane0", 32'(o_addr3), 32'h0);
      chk("c3 lane0 o_ac", o_ac3, 32'h0000_0C00);
      step();
      $display("[TB] c3 vld=%0b addr=%0d ac=%h", o_vld3, o_addr3, o_ac3);
      chk("c3 grant lane1", 32'(o_addr3), 32'h1);
      step();
      chk("c3 drained", 32'(o_vld3), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
